// File: rtl/snn_pkg.sv
// snn_pkg: shared widths and FSM state encoding for the LIF neuron scanner.
//   NUM_SYN  - number of presynaptic inputs scanned per timestep
//   WEIGHT_W - width of one synaptic weight
//   MEM_W    - width of the membrane potential and the weighted sum
`timescale 1ns/1ps
package snn_pkg;
  localparam int NUM_SYN  = 16;
  localparam int WEIGHT_W = 4;
  localparam int MEM_W    = 8;
  localparam int ADDR_W   = $clog2(NUM_SYN);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    DRAIN,
    UPDATE,
    REFRACT
  } state_t;
endpackage

// File: rtl/lif_update.sv
// lif_update: combinational membrane update for one timestep.
//   i_v      - current membrane potential
//   i_sum    - weighted sum of active synapses for this timestep
//   o_v_next - min(255, v - (v >> LEAK_SHIFT) + sum)
//   o_fire   - o_v_next has reached THRESHOLD
`timescale 1ns/1ps
module lif_update import snn_pkg::*; #(
  parameter logic [MEM_W-1:0] THRESHOLD  = 8'd64,
  parameter int               LEAK_SHIFT = 3
) (
  input  logic [MEM_W-1:0] i_v,
  input  logic [MEM_W-1:0] i_sum,
  output logic [MEM_W-1:0] o_v_next,
  output logic             o_fire
);
  logic [MEM_W-1:0] w_leak;
  logic [MEM_W-1:0] w_leaked;
  logic [MEM_W:0]   w_total;

  // v >> k never exceeds v, so the subtraction cannot underflow.
  assign w_leak   = i_v >> LEAK_SHIFT;
  assign w_leaked = i_v - w_leak;
  // One extra bit catches the carry used for saturation.
  assign w_total  = {1'b0, w_leaked} + {1'b0, i_sum};
  assign o_v_next = w_total[MEM_W] ? {MEM_W{1'b1}} : w_total[MEM_W-1:0];
  assign o_fire   = (o_v_next >= THRESHOLD);
endmodule

// File: rtl/lif_neuron_scanner.sv
// lif_neuron_scanner: leaky integrate-and-fire neuron that scans 16 synaptic
// weights from an external memory once per timestep.
//   i_clock, i_reset   - clock and synchronous active-high reset
//   i_step_valid       - timestep request; i_pre_spikes valid with it
//   o_step_ready       - high in IDLE only; accept = valid && ready
//   i_pre_spikes       - presynaptic spike vector, latched on accept
//   o_w_rd, o_w_addr   - weight read strobe and synapse index
//   i_w_data           - weight, returned the cycle after o_w_rd
//   o_post_spike       - one-cycle output spike
//   o_done             - one-cycle timestep completion pulse
//   o_membrane         - registered membrane potential
`timescale 1ns/1ps
module lif_neuron_scanner import snn_pkg::*; #(
  parameter logic [MEM_W-1:0] THRESHOLD     = 8'd64,
  parameter int               LEAK_SHIFT    = 3,
  parameter int               REFRACT_STEPS = 2
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_step_valid,
  output logic                o_step_ready,
  input  logic [NUM_SYN-1:0]  i_pre_spikes,
  output logic                o_w_rd,
  output logic [ADDR_W-1:0]   o_w_addr,
  input  logic [WEIGHT_W-1:0] i_w_data,
  output logic                o_post_spike,
  output logic                o_done,
  output logic [MEM_W-1:0]    o_membrane
);
  localparam int               RCNT_W       = 8;
  localparam logic [RCNT_W-1:0] REFRACT_LOAD = RCNT_W'(REFRACT_STEPS);

  state_t              r_state;
  state_t              w_state_next;
  logic [NUM_SYN-1:0]  r_spikes;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_addr_prev;
  logic                r_rd_prev;
  logic [MEM_W-1:0]    r_sum;
  logic [MEM_W-1:0]    r_membrane;
  logic [RCNT_W-1:0]   r_refract;
  logic                r_done;
  logic                r_post_spike;

  logic                w_ready;
  logic                w_rd;
  logic                w_accept;
  logic [NUM_SYN-1:0]  w_hit_vec;
  logic                w_hit;
  logic [MEM_W-1:0]    w_v_next;
  logic                w_fire;

  // State register.
  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (i_step_valid) w_state_next = (r_refract != '0) ? REFRACT : SCAN;
      SCAN:    if (r_addr == ADDR_W'(NUM_SYN-1)) w_state_next = DRAIN;
      DRAIN:   w_state_next = UPDATE;
      UPDATE:  w_state_next = IDLE;
      REFRACT: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    w_ready  = (r_state == IDLE);
    w_rd     = (r_state == SCAN);
    w_accept = w_ready & i_step_valid;
  end

  // Spike bit of the address read last cycle; its weight is on i_w_data now.
  generate
    for (genvar gi = 0; gi < NUM_SYN; gi++) begin : g_hit
      assign w_hit_vec[gi] = r_spikes[gi] & (r_addr_prev == ADDR_W'(gi));
    end
  endgenerate
  assign w_hit = |w_hit_vec;

  lif_update #(
    .THRESHOLD  (THRESHOLD),
    .LEAK_SHIFT (LEAK_SHIFT)
  ) u_update (
    .i_v      (r_membrane),
    .i_sum    (r_sum),
    .o_v_next (w_v_next),
    .o_fire   (w_fire)
  );

  // Datapath: address counter, accumulator, membrane and refractory counter.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_spikes     <= '0;
      r_addr       <= '0;
      r_addr_prev  <= '0;
      r_rd_prev    <= 1'b0;
      r_sum        <= '0;
      r_membrane   <= '0;
      r_refract    <= '0;
      r_done       <= 1'b0;
      r_post_spike <= 1'b0;
    end else begin
      r_done       <= 1'b0;
      r_post_spike <= 1'b0;
      r_rd_prev    <= w_rd;
      r_addr_prev  <= r_addr;

      if (w_accept) begin
        r_spikes <= i_pre_spikes;
        r_sum    <= '0;
        r_addr   <= '0;
      end else if (r_rd_prev && w_hit) begin
        // 16 x 15 = 240 max, fits in 8 bits.
        r_sum <= r_sum + MEM_W'(i_w_data);
      end

      // Wraps to 0 after the last address, leaving w_addr at 0 in IDLE.
      if (w_rd) r_addr <= r_addr + ADDR_W'(1);

      if (r_state == UPDATE) begin
        r_done <= 1'b1;
        if (w_fire) begin
          r_post_spike <= 1'b1;
          r_membrane   <= '0;
          r_refract    <= REFRACT_LOAD;
        end else begin
          r_membrane <= w_v_next;
        end
      end

      // Only entered with a nonzero counter, so the decrement cannot wrap.
      if (r_state == REFRACT) begin
        r_done     <= 1'b1;
        r_membrane <= '0;
        r_refract  <= r_refract - RCNT_W'(1);
      end
    end
  end

  assign o_step_ready = w_ready;
  assign o_w_rd       = w_rd;
  assign o_w_addr     = r_addr;
  assign o_post_spike = r_post_spike;
  assign o_done       = r_done;
  assign o_membrane   = r_membrane;
endmodule

// File: tb/tb_lif_neuron_scanner.sv
// tb_lif_neuron_scanner: two scanner instances (default threshold and
// threshold 255) driven from a vector table, with expected step results
// queued at accept time and checked when done pulses.
`timescale 1ns/1ps
module tb_lif_neuron_scanner;
  typedef struct {
    int         inst;
    int         wsel;   // 0: all 4, 1: w[k]=k, 2: all 15, 3: w[3]=7 else 0
    logic [15:0] pre;
    logic [7:0] mem;
    logic       spike;
    int         lat;
    int         rds;
  } vec_t;

  typedef struct {
    logic [7:0] mem;
    logic       spike;
    int         lat;
    int         rds;
  } exp_t;

  localparam int NVEC = 16;

  logic        clk;
  logic        rst;
  logic        step_valid [2];
  logic        step_ready [2];
  logic [15:0] pre_spikes [2];
  logic        w_rd       [2];
  logic [3:0]  w_addr     [2];
  logic [3:0]  w_data     [2];
  logic        post_spike [2];
  logic        done       [2];
  logic [7:0]  membrane   [2];
  logic [3:0]  wmem       [2][16];

  int checks = 0;
  int errors = 0;
  int cyc[2];
  int rdc[2];
  int done_cnt[2];
  int acc_cnt[2];
  bit active[2];
  exp_t q_a[$];
  exp_t q_b[$];
  vec_t tbl[NVEC];

  lif_neuron_scanner u_dut_a (
    .i_clock(clk), .i_reset(rst), .i_step_valid(step_valid[0]),
    .o_step_ready(step_ready[0]), .i_pre_spikes(pre_spikes[0]),
    .o_w_rd(w_rd[0]), .o_w_addr(w_addr[0]), .i_w_data(w_data[0]),
    .o_post_spike(post_spike[0]), .o_done(done[0]), .o_membrane(membrane[0])
  );

  lif_neuron_scanner #(.THRESHOLD(8'd255)) u_dut_b (
    .i_clock(clk), .i_reset(rst), .i_step_valid(step_valid[1]),
    .o_step_ready(step_ready[1]), .i_pre_spikes(pre_spikes[1]),
    .o_w_rd(w_rd[1]), .o_w_addr(w_addr[1]), .i_w_data(w_data[1]),
    .o_post_spike(post_spike[1]), .o_done(done[1]), .o_membrane(membrane[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Weight memory with one cycle of read latency.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) w_data[i] <= wmem[i][w_addr[i]];
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int i, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s inst=%0d actual=%0d required=%0d", name, i, act, req);
    end
  endtask

  task automatic set_weights(input int i, input int wsel);
    for (int k = 0; k < 16; k++) begin
      case (wsel)
        0:       wmem[i][k] = 4'd4;
        1:       wmem[i][k] = 4'(k);
        2:       wmem[i][k] = 4'd15;
        default: wmem[i][k] = (k == 3) ? 4'd7 : 4'd0;
      endcase
    end
  endtask

  task automatic push_exp(input int i, input exp_t e);
    if (i == 0) q_a.push_back(e);
    else        q_b.push_back(e);
  endtask

  // Observes both instances at the falling edge; cyc counts cycles after accept.
  task automatic monitor();
    exp_t e;
    bit   have;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          active[i] = 1'b0;
        end else begin
          if (active[i]) begin
            cyc[i]++;
            if (w_rd[i]) begin
              chk("w_addr_seq", i, int'(w_addr[i]), rdc[i]);
              rdc[i]++;
            end
            if (done[i]) begin
              done_cnt[i]++;
              active[i] = 1'b0;
              have = 1'b0;
              if (i == 0 && q_a.size() > 0) begin e = q_a.pop_front(); have = 1'b1; end
              if (i == 1 && q_b.size() > 0) begin e = q_b.pop_front(); have = 1'b1; end
              if (!have) begin
                chk("done_without_expectation", i, 1, 0);
              end else begin
                $display("step inst=%0d lat=%0d rds=%0d mem=%0d spike=%0d", i, cyc[i], rdc[i],
                         membrane[i], post_spike[i]);
                chk("latency", i, cyc[i], e.lat);
                chk("w_rd_count", i, rdc[i], e.rds);
                chk("membrane", i, int'(membrane[i]), int'(e.mem));
                chk("post_spike", i, int'(post_spike[i]), int'(e.spike));
                chk("ready_at_done", i, int'(step_ready[i]), 1);
              end
            end
          end else if (done[i]) begin
            chk("unexpected_done", i, 1, 0);
          end
          if (step_valid[i] && step_ready[i]) begin
            active[i] = 1'b1;
            cyc[i] = 0;
            rdc[i] = 0;
            acc_cnt[i]++;
          end
        end
      end
    end
  endtask

  task automatic wait_ready(input int i);
    int n = 0;
    @(negedge clk);
    while (!step_ready[i] && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) chk("ready_timeout", i, 0, 1);
  endtask

  task automatic wait_done(input int i, input int target);
    int n = 0;
    while (done_cnt[i] < target && n < 300) begin @(posedge clk); #1; n++; end
    if (n >= 300) chk("done_timeout", i, done_cnt[i], target);
  endtask

  task automatic run_step(input int i, input logic [15:0] pre, input exp_t e);
    int base;
    wait_ready(i);
    @(posedge clk); #1;
    base = done_cnt[i];
    push_exp(i, e);
    step_valid[i] = 1'b1;
    pre_spikes[i] = pre;
    @(posedge clk); #1;
    step_valid[i] = 1'b0;
    pre_spikes[i] = ~pre;   // must not matter once latched
    wait_done(i, base + 1);
  endtask

  function automatic vec_t mk(input int inst, input int wsel, input logic [15:0] pre,
                              input logic [7:0] mem, input logic spike, input bit scan);
    vec_t v;
    v.inst = inst; v.wsel = wsel; v.pre = pre; v.mem = mem; v.spike = spike;
    v.lat = scan ? 19 : 2;
    v.rds = scan ? 16 : 0;
    return v;
  endfunction

  initial begin
    exp_t e;
    int   base;
    int   abase;
    int   n;

    // Instance 0: THRESHOLD 64, LEAK_SHIFT 3, REFRACT_STEPS 2.
    tbl[0]  = mk(0, 0, 16'hFFFF, 8'd0,   1'b1, 1'b1); // sum 64 -> fire
    tbl[1]  = mk(0, 0, 16'hFFFF, 8'd0,   1'b0, 1'b0); // refractory 1
    tbl[2]  = mk(0, 0, 16'hFFFF, 8'd0,   1'b0, 1'b0); // refractory 2
    tbl[3]  = mk(0, 1, 16'hC800, 8'd40,  1'b0, 1'b1); // 15+14+11
    tbl[4]  = mk(0, 1, 16'h0000, 8'd35,  1'b0, 1'b1); // 40-5
    tbl[5]  = mk(0, 1, 16'h8001, 8'd46,  1'b0, 1'b1); // 35-4+0+15
    tbl[6]  = mk(0, 0, 16'h00F0, 8'd57,  1'b0, 1'b1); // 46-5+16
    tbl[7]  = mk(0, 1, 16'h2000, 8'd63,  1'b0, 1'b1); // 57-7+13, just below
    tbl[8]  = mk(0, 1, 16'h0100, 8'd0,   1'b1, 1'b1); // 63-7+8 = 64 fires
    tbl[9]  = mk(0, 1, 16'hFFFF, 8'd0,   1'b0, 1'b0);
    tbl[10] = mk(0, 1, 16'hFFFF, 8'd0,   1'b0, 1'b0);
    tbl[11] = mk(0, 3, 16'h0008, 8'd7,   1'b0, 1'b1); // only addr 3
    tbl[12] = mk(0, 3, 16'hF7F7, 8'd7,   1'b0, 1'b1); // addr 3 masked off
    // Instance 1: THRESHOLD 255.
    tbl[13] = mk(1, 2, 16'hFFFF, 8'd240, 1'b0, 1'b1);
    tbl[14] = mk(1, 2, 16'hFFFF, 8'd0,   1'b1, 1'b1); // 210+240 -> 255
    tbl[15] = mk(1, 2, 16'hFFFF, 8'd0,   1'b0, 1'b0);

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step_valid[i] = 1'b0;
      pre_spikes[i] = '0;
      cyc[i] = 0; rdc[i] = 0; done_cnt[i] = 0; acc_cnt[i] = 0; active[i] = 1'b0;
      set_weights(i, 0);
    end
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_step_ready", 0, int'(step_ready[0]), 1);
    chk("rst_w_rd",       0, int'(w_rd[0]), 0);
    chk("rst_w_addr",     0, int'(w_addr[0]), 0);
    chk("rst_post_spike", 0, int'(post_spike[0]), 0);
    chk("rst_done",       0, int'(done[0]), 0);
    chk("rst_membrane",   0, int'(membrane[0]), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int t = 0; t < NVEC; t++) begin
      set_weights(tbl[t].inst, tbl[t].wsel);
      e.mem = tbl[t].mem; e.spike = tbl[t].spike; e.lat = tbl[t].lat; e.rds = tbl[t].rds;
      run_step(tbl[t].inst, tbl[t].pre, e);
    end

    // Reset in the middle of a scan: aborts with no done pulse.
    set_weights(0, 0);
    wait_ready(0);
    base = done_cnt[0];
    @(posedge clk); #1;
    step_valid[0] = 1'b1;
    pre_spikes[0] = 16'hFFFF;
    @(posedge clk); #1;                 // cycle 1 after accept
    step_valid[0] = 1'b0;
    repeat (7) @(posedge clk);
    #1;                                 // cycle 8
    chk("scan8_w_rd",   0, int'(w_rd[0]), 1);
    chk("scan8_w_addr", 0, int'(w_addr[0]), 7);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_step_ready", 0, int'(step_ready[0]), 1);
    chk("abort_w_rd",       0, int'(w_rd[0]), 0);
    chk("abort_w_addr",     0, int'(w_addr[0]), 0);
    chk("abort_membrane",   0, int'(membrane[0]), 0);
    chk("abort_done",       0, int'(done[0]), 0);

    // Reset wins over a simultaneous step request.
    @(posedge clk); #1;
    rst = 1'b1;
    step_valid[0] = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    step_valid[0] = 1'b0;
    @(negedge clk);
    chk("rst_prio_ready", 0, int'(step_ready[0]), 1);
    chk("rst_prio_w_rd",  0, int'(w_rd[0]), 0);
    repeat (30) @(posedge clk);
    #1;
    chk("abort_no_done", 0, done_cnt[0], base);

    // Instance 1 was refractory before the reset; reset clears the counter.
    set_weights(1, 2);
    e.mem = 8'd15; e.spike = 1'b0; e.lat = 19; e.rds = 16;
    run_step(1, 16'h0001, e);

    // step_valid held high: one accept per IDLE visit, sum 7 each time.
    set_weights(0, 3);
    e.spike = 1'b0; e.lat = 19; e.rds = 16;
    e.mem = 8'd7;  push_exp(0, e);
    e.mem = 8'd14; push_exp(0, e);
    e.mem = 8'd20; push_exp(0, e);
    e.mem = 8'd25; push_exp(0, e);
    wait_ready(0);
    base  = done_cnt[0];
    abase = acc_cnt[0];
    @(posedge clk); #1;
    step_valid[0] = 1'b1;
    pre_spikes[0] = 16'h0008;
    n = 0;
    while (done_cnt[0] < base + 3 && n < 300) begin @(posedge clk); #1; n++; end
    if (n >= 300) chk("held_valid_timeout", 0, done_cnt[0], base + 3);
    step_valid[0] = 1'b0;
    wait_done(0, base + 4);
    repeat (25) @(posedge clk);
    #1;
    chk("held_valid_accepts", 0, acc_cnt[0] - abase, 4);
    chk("held_valid_dones",   0, done_cnt[0] - base, 4);
    chk("queue_a_empty",      0, q_a.size(), 0);
    chk("queue_b_empty",      1, q_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lif_neuron_scanner.md
LIF_NEURON_SCANNER -- requirements
Module: lif_neuron_scanner

Interface
REQ-001 SHALL have parameter THRESHOLD, default 8'd64: firing threshold on the membrane potential.
REQ-002 SHALL have parameter LEAK_SHIFT, default 3: per-step leak is v >> LEAK_SHIFT.
REQ-003 SHALL have parameter REFRACT_STEPS, default 2: timesteps skipped after a spike.
REQ-004 clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 step_valid  in  1  new timestep available; pre_spikes valid while high.
REQ-007 step_ready  out  1  block can accept a timestep.
REQ-008 pre_spikes  in  16  presynaptic spike vector; bit k = synapse k.
REQ-009 w_rd  out  1  weight read strobe.
REQ-010 w_addr  out  4  synapse index being read.
REQ-011 w_data  in  4  unsigned weight; valid the cycle after w_rd.
REQ-012 post_spike  out  1  one-cycle postsynaptic spike pulse.
REQ-013 done  out  1  one-cycle pulse marking timestep completion.
REQ-014 membrane  out  8  unsigned membrane potential, registered.

Function
REQ-015 SHALL implement FSM states IDLE, SCAN, DRAIN, UPDATE, REFRACT.
REQ-016 SHALL hold step_ready high only in IDLE; a step is accepted on an edge with step_valid && step_ready, and pre_spikes SHALL be latched at that edge.
REQ-017 When accepted with the refractory counter at 0, the FSM SHALL enter SCAN and drive w_rd=1 with w_addr 0..15 for 16 consecutive cycles, regardless of pre_spikes.
REQ-018 SHALL add w_data to an 8-bit sum only when the latched spike bit for the address issued in the previous cycle is 1; maximum sum is 240, so there is no overflow.
REQ-019 DRAIN SHALL last one cycle, capturing the address-15 data with w_rd=0.
REQ-020 UPDATE SHALL compute v_next = min(255, v - (v >> LEAK_SHIFT) + sum).
REQ-021 If v_next >= THRESHOLD, UPDATE SHALL fire: post_spike pulses, membrane goes to 0, and the refractory counter loads REFRACT_STEPS. Otherwise membrane takes v_next.
REQ-022 post_spike, done and the new membrane value SHALL become visible in cycle 19 after the accept edge, and step_ready SHALL be high in that same cycle.
REQ-023 When accepted with the refractory counter nonzero, the FSM SHALL enter REFRACT for one cycle with no w_rd, membrane held at 0, and the counter decremented. done SHALL pulse in cycle 2 after accept, and post_spike SHALL stay 0.
REQ-024 step_valid while step_ready is low SHALL be ignored, and no request is queued.
REQ-025 The sum SHALL clear on every accept.

Reset
REQ-026 reset SHALL force IDLE, step_ready=1, w_rd=0, w_addr=0, post_spike=0, done=0, membrane=0, refractory counter=0 and sum=0 at the next edge, including mid-SCAN. A reset aborts the step with no done pulse.
REQ-027 reset SHALL have priority over step_valid on the same edge.

Structure
REQ-028 Package snn_pkg SHALL hold NUM_SYN=16, WEIGHT_W=4, MEM_W=8 and the FSM state enum.
REQ-029 Leak, saturation and threshold compare SHALL live in the combinational sub-module lif_update; FSM, counters and accumulator stay in lif_neuron_scanner.

Verification
REQ-030 Scenario 1: all weights 4, pre_spikes=16'hFFFF, v=0 -> sum 64; in cycle 19 post_spike=1, done=1, membrane=0.
REQ-031 Scenario 2: membrane preset to 40, pre_spikes=0 -> 16 w_rd cycles, no spike, membrane=35.
REQ-032 Scenario 3: weights 15, pre_spikes=16'hFFFF, twice with THRESHOLD=8'd255 -> the first step gives membrane 240; the second gives 210+240, saturated to 255, with post_spike=1 and membrane=0.
REQ-033 Scenario 4: after a fire, the next 2 steps each give done in cycle 2 with no w_rd and membrane 0; the 3rd step performs a full scan.
REQ-034 Scenario 5: reset asserted at SCAN cycle 8 -> next cycle step_ready=1, w_rd=0, membrane=0, and no done pulse.
REQ-035 Scenario 6: step_valid held high through a scan with weights at addr 3 = 7 and pre_spikes=16'h0008 -> exactly one step accepted per IDLE visit, and the sum is 7 each step.
